// File: rtl/bnn_pkg.sv
// Shared BNN definitions: FSM state encoding and default layer dimensions.
package bnn_pkg;

    localparam int unsigned BNN_HID_W       = 4;
    localparam int unsigned BNN_NUM_CLASSES = 4;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } bnn_state_t;

endpackage

// File: rtl/bnn_xnor_popcount.sv
// Combinational XNOR-popcount: counts the bit positions where the hidden vector matches the weight.
module bnn_xnor_popcount #(
    parameter int unsigned HID_W   = 4,
    parameter int unsigned SCORE_W = 3
) (
    input  logic [HID_W-1:0]   hid,
    input  logic [HID_W-1:0]   weight,
    output logic [SCORE_W-1:0] score
);

    always_comb begin
        score = '0;
        for (int unsigned i = 0; i < HID_W; i++) begin
            score = score + SCORE_W'(hid[i] ~^ weight[i]);
        end
    end

endmodule

// File: rtl/bnn_output_classifier.sv
// BNN output stage: iterative XNOR-popcount argmax over NUM_CLASSES loadable class weights.
// Define BNN_CLS_MARGIN_EN to build the second-best tracker and the out_margin port.
module bnn_output_classifier
    import bnn_pkg::*;
#(
    parameter int unsigned HID_W       = BNN_HID_W,
    parameter int unsigned NUM_CLASSES = BNN_NUM_CLASSES,
    parameter int unsigned CLS_W       = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
    parameter int unsigned SCORE_W     = $clog2(HID_W + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hid_valid,
    output logic               hid_ready,
    input  logic [HID_W-1:0]   hid_data,
    input  logic               wload_en,
    input  logic [HID_W-1:0]   wload_data,
    output logic               out_valid,
    input  logic               out_ready,
`ifdef BNN_CLS_MARGIN_EN
    output logic [SCORE_W-1:0] out_margin,
`endif
    output logic [CLS_W-1:0]   out_class,
    output logic [SCORE_W-1:0] out_score
);

    localparam logic [CLS_W-1:0] LAST = CLS_W'(NUM_CLASSES - 1);

    bnn_state_t         state, state_next;
    logic [HID_W-1:0]   weights [NUM_CLASSES];
    logic [CLS_W-1:0]   wptr, cnt, best_idx, idx_next;
    logic [HID_W-1:0]   hid_reg;
    logic [SCORE_W-1:0] score, best, best_next;
    logic               load, accept, last;

    bnn_xnor_popcount #(
        .HID_W   (HID_W),
        .SCORE_W (SCORE_W)
    ) u_popcount (
        .hid    (hid_reg),
        .weight (weights[cnt]),
        .score  (score)
    );

    assign out_valid = (state == DONE);

    always_comb begin
        state_next = state;
        hid_ready  = 1'b0;
        load       = 1'b0;
        accept     = 1'b0;
        last       = (cnt == LAST);
        case (state)
            IDLE: begin
                hid_ready = !wload_en;
                load      = wload_en;
                accept    = hid_valid && !wload_en;
                if (accept) state_next = SCAN;
            end
            SCAN:    if (last) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Class 0 seeds best unconditionally; later classes must strictly beat it.
    always_comb begin
        best_next = best;
        idx_next  = best_idx;
        if (cnt == '0 || score > best) begin
            best_next = score;
            idx_next  = cnt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr      <= '0;
            cnt       <= '0;
            hid_reg   <= '0;
            best      <= '0;
            best_idx  <= '0;
            out_class <= '0;
            out_score <= '0;
            for (int unsigned i = 0; i < NUM_CLASSES; i++) weights[i] <= '0;
        end else begin
            if (load) begin
                weights[wptr] <= wload_data;
                wptr          <= (wptr == LAST) ? '0 : wptr + CLS_W'(1);
            end
            if (accept) begin
                hid_reg  <= hid_data;
                cnt      <= '0;
                best     <= '0;
                best_idx <= '0;
            end
            if (state == SCAN) begin
                best     <= best_next;
                best_idx <= idx_next;
                cnt      <= last ? '0 : cnt + CLS_W'(1);
                // Result registers capture the final class too, so they hold through IDLE.
                if (last) begin
                    out_class <= idx_next;
                    out_score <= best_next;
                end
            end
        end
    end

`ifdef BNN_CLS_MARGIN_EN
    logic [SCORE_W-1:0] second, second_next;

    // A dethroned best becomes second; ties with best also land here.
    always_comb begin
        second_next = second;
        if (cnt == '0)               second_next = '0;
        else if (score > best)       second_next = best;
        else if (score > second)     second_next = score;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            second     <= '0;
            out_margin <= '0;
        end else begin
            if (accept) second <= '0;
            if (state == SCAN) begin
                second <= second_next;
                if (last) out_margin <= best_next - second_next;
            end
        end
    end
`endif

endmodule
